sender: RTL and testbench

Serializing transmitter for the register-storage path. Captures a `buffer_size`-bit parallel word on a start request, then presents it one bit per active cycle on `txda`. Each bit is qualified by an active-low `oeenable` strobe and carries its bit index in the upper field of `ramadrs`, so the downstream storage block rebuilds the word bit-for-bit. Sits between the data producer and the storage block, on the same `clock`.

---
 rtl/store_pkg.sv | 37 +++
 rtl/bit_index_counter.sv | 57 +++++
 rtl/sender.sv | 155 +++++++++++++++
 tb/tb_sender.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_pkg
//  Description : Definitions shared by the sender and the storage block.
//                Holds the FSM state encoding, the default counter/buffer
//                widths, and a helper that returns the field boundaries
//                inside the ramadrs bus.
//  Revision    : 1.0  initial release
// ============================================================================
package store_pkg;

    localparam int c_def_counter_size = 3;
    localparam int c_def_buffer_size  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ramadrs layout: [idx_hi:idx_lo] = bit index, [frm_hi:0] = frame count
    typedef struct packed {
        int idx_hi;
        int idx_lo;
        int frm_hi;
    } ramadrs_fields_t;

    function automatic ramadrs_fields_t ramadrs_fields(input int counter_size);
        ramadrs_fields_t f;
        f.idx_hi = 2 * counter_size;
        f.idx_lo = counter_size + 1;
        f.frm_hi = counter_size;
        return f;
    endfunction

endpackage : store_pkg
`default_nettype wire

// File: rtl/bit_index_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_index_counter
//  Description : Loadable, enabled counter_size-bit counter that tracks which
//                bit of the captured word is sent next. o_tc flags the last
//                bit index (buffer_size-1).
//  Ports       : clock      - rising-edge clock
//                reset      - asynchronous active-low reset
//                i_load     - load i_load_val (wins over i_en)
//                i_load_val - value loaded on i_load
//                i_en       - advance by one
//                o_count    - current index
//                o_tc       - high while o_count == buffer_size-1
//  Revision    : 1.0  initial release
// ============================================================================
module bit_index_counter
    import store_pkg::*;
#(
    parameter int counter_size = c_def_counter_size,
    parameter int buffer_size  = c_def_buffer_size
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [counter_size-1:0] i_load_val,
    input  logic                    i_en,
    output logic [counter_size-1:0] o_count,
    output logic                    o_tc
);

    localparam logic [counter_size-1:0] c_last = counter_size'(buffer_size - 1);

    logic [counter_size-1:0] count_q;
    logic [counter_size-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = (count_q == c_last);

endmodule : bit_index_counter
`default_nettype wire

// File: rtl/sender.sv
`default_nettype none
// ============================================================================
//  Module      : sender
//  Description : Serializing transmitter. Captures a buffer_size-bit word on
//                start and sends it LSB first, one bit per non-stalled cycle,
//                with an active-low strobe and the bit index / frame count
//                on ramadrs so the storage block can rebuild the word.
//  Ports       : clock    - rising-edge clock
//                reset    - asynchronous active-low reset
//                start    - send request (sampled in IDLE only)
//                stall    - hold current bit, suppress strobe
//                data     - word to send, captured on accepted start
//                oeenable - active-low bit strobe
//                ramadrs  - {bit index, frame count}
//                txda     - serial data bit
//                busy     - frame in progress
//                done     - one-cycle end-of-frame pulse
//  Revision    : 1.0  initial release
// ============================================================================
module sender
    import store_pkg::*;
#(
    parameter int counter_size = c_def_counter_size,
    parameter int buffer_size  = c_def_buffer_size
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stall,
    input  logic [buffer_size-1:0]    data,
    output logic                      oeenable,
    output logic [2*counter_size:0]   ramadrs,
    output logic                      txda,
    output logic                      busy,
    output logic                      done
);

    localparam ramadrs_fields_t c_fields = ramadrs_fields(counter_size);
    localparam int c_idx_hi = c_fields.idx_hi;
    localparam int c_idx_lo = c_fields.idx_lo;
    localparam int c_frm_hi = c_fields.frm_hi;
    localparam logic [counter_size-1:0] c_idx_first = '0;

    state_t                  state_q, state_d;
    logic [buffer_size-1:0]  shreg_q, shreg_d;
    logic [counter_size:0]   frame_q, frame_d;
    logic [counter_size-1:0] idx_q,   idx_d;
    logic                    oe_q,    oe_d;
    logic                    txda_q,  txda_d;
    logic                    busy_q,  busy_d;
    logic                    done_q,  done_d;

    logic                    cnt_load;
    logic                    cnt_en;
    logic [counter_size-1:0] cnt_value;
    logic                    cnt_tc;

    bit_index_counter #(
        .counter_size (counter_size),
        .buffer_size  (buffer_size)
    ) u_bit_index_counter (
        .clock      (clock),
        .reset      (reset),
        .i_load     (cnt_load),
        .i_load_val (c_idx_first),
        .i_en       (cnt_en),
        .o_count    (cnt_value),
        .o_tc       (cnt_tc)
    );

    // Outputs are computed one edge ahead and registered, so the stall seen
    // at an edge decides whether the cycle launched by that edge strobes.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        oe_d     = 1'b1;
        txda_d   = txda_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shreg_d  = data;
                    cnt_load = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                if (!stall) begin
                    // Word is shifted LSB first, so bit [0] always matches
                    // the index held by the counter.
                    oe_d    = 1'b0;
                    txda_d  = shreg_q[0];
                    idx_d   = cnt_value;
                    shreg_d = shreg_q >> 1;
                    cnt_en  = 1'b1;
                    if (cnt_tc) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                frame_d = frame_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            oe_q    <= 1'b1;
            txda_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            oe_q    <= oe_d;
            txda_q  <= txda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        ramadrs                    = '0;
        ramadrs[c_idx_hi:c_idx_lo] = idx_q;
        ramadrs[c_frm_hi:0]        = frame_q;
    end

    assign oeenable = oe_q;
    assign txda     = txda_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : sender
`default_nettype wire

// File: tb/tb_sender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sender
//  Description : Self-checking bench for sender (counter_size=3,
//                buffer_size=8). A queue-based frame model predicts every
//                output each cycle; directed frames pin the model with
//                hand-computed words, latencies and frame counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sender;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stall;
    logic [7:0] data;
    logic       oeenable;
    logic [6:0] ramadrs;
    logic       txda;
    logic       busy;
    logic       done;

    sender #(
        .counter_size (3),
        .buffer_size  (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stall    (stall),
        .data     (data),
        .oeenable (oeenable),
        .ramadrs  (ramadrs),
        .txda     (txda),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clock) cyc++;

    // ------------------------------------------------------------------
    // Model: a frame is a queue of bit indices still to be strobed. Each
    // edge either ends a frame, strobes the head index (unless stalled),
    // or accepts a new word when nothing is pending.
    // ------------------------------------------------------------------
    int         m_q[$];
    logic [7:0] m_word;
    bit         m_done_pend;
    int         m_frame;
    logic       e_oe, e_txda, e_busy, e_done;
    logic [2:0] e_idx;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_word      = '0;
            m_done_pend = 1'b0;
            m_frame     = 0;
            e_oe = 1'b1; e_txda = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
        end else begin
            e_oe   = 1'b1;
            e_done = 1'b0;
            if (m_done_pend) begin
                e_done      = 1'b1;
                e_busy      = 1'b0;
                m_done_pend = 1'b0;
                m_frame     = (m_frame + 1) % 16;
            end else if (m_q.size() > 0) begin
                e_busy = 1'b1;
                if (!stall) begin
                    e_oe   = 1'b0;
                    e_idx  = 3'(m_q.pop_front());
                    e_txda = m_word[e_idx];
                    if (m_q.size() == 0) m_done_pend = 1'b1;
                end
            end else begin
                e_busy = 1'b0;
                if (start) begin
                    m_word = data;
                    for (int i = 0; i < 8; i++) m_q.push_back(i);
                end
            end
        end
    end

    logic [3:0] e_frame;
    assign e_frame = m_frame[3:0];

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            chk("oeenable", {31'd0, oeenable}, {31'd0, e_oe});
            chk("txda",     {31'd0, txda},     {31'd0, e_txda});
            chk("ramadrs",  {25'd0, ramadrs},  {25'd0, e_idx, e_frame});
            chk("busy",     {31'd0, busy},     {31'd0, e_busy});
            chk("done",     {31'd0, done},     {31'd0, e_done});
        end
    end

    // Called at a negedge; start is visible at the next edge. Returns at the
    // negedge of the done cycle so a following call is back-to-back.
    task automatic send(input logic [7:0] d, input logic [15:0] smask,
                        input int start_k, input int rst_k,
                        output logic [7:0] word, output int done_k,
                        output int first_lower, output int acc);
        start = 1'b1;
        data  = d;
        @(negedge clock);
        start       = 1'b0;
        acc         = cyc;
        word        = '0;
        done_k      = -1;
        first_lower = -1;
        for (int k = 1; k <= 40; k++) begin
            stall = (k < 16) ? smask[k] : 1'b0;
            if (k == start_k) begin
                start = 1'b1;
                data  = ~d;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (oeenable === 1'b0) begin
                word[ramadrs[6:4]] = txda;
                if (first_lower < 0) first_lower = int'(ramadrs[3:0]);
            end
            if (stall) chk("stall_oe_high", {31'd0, oeenable}, 32'd1);
            if (k == start_k) chk("busy_at_ignored_start", {31'd0, busy}, 32'd1);
            if (k == rst_k) begin
                #2 reset = 1'b0;
                #1;
                chk("async_rst_oe",      {31'd0, oeenable}, 32'd1);
                chk("async_rst_busy",    {31'd0, busy},     32'd0);
                chk("async_rst_ramadrs", {25'd0, ramadrs},  32'd0);
                chk("async_rst_txda",    {31'd0, txda},     32'd0);
                chk("async_rst_done",    {31'd0, done},     32'd0);
                stall = 1'b0;
                start = 1'b0;
                @(posedge clock);
                @(negedge clock);
                reset  = 1'b1;
                done_k = 0;
                break;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        if (done_k < 0) chk("done_timeout", 32'hFFFF_FFFF, 32'd0);
    endtask

    logic [7:0] w;
    logic [7:0] d;
    int         dk, fl, acc, prev_acc;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        data  = '0;
        repeat (2) @(negedge clock);
        chk("rst_oe",      {31'd0, oeenable}, 32'd1);
        chk("rst_ramadrs", {25'd0, ramadrs},  32'd0);
        chk("rst_busy",    {31'd0, busy},     32'd0);
        chk("rst_done",    {31'd0, done},     32'd0);
        chk_en = 1'b1;
        reset  = 1'b1;
        @(negedge clock);

        // Plain frame: A5 = bits 1,0,1,0,0,1,0,1 LSB first
        send(8'hA5, 16'h0000, 0, 0, w, dk, fl, acc);
        chk("a5_word", {24'd0, w}, 32'h0000_00A5);
        chk("a5_done_cycle", dk, 32'd9);
        chk("a5_frame", fl, 32'd0);
        repeat (2) @(negedge clock);

        // Stall in cycles 3..5 adds three cycles
        send(8'h3C, 16'h0038, 0, 0, w, dk, fl, acc);
        chk("3c_word", {24'd0, w}, 32'h0000_003C);
        chk("3c_done_cycle", dk, 32'd12);
        chk("3c_frame", fl, 32'd1);
        repeat (3) @(negedge clock);

        // start pulse and data change in cycle 4 are ignored
        send(8'h5A, 16'h0000, 4, 0, w, dk, fl, acc);
        chk("ign_word", {24'd0, w}, 32'h0000_005A);
        chk("ign_done_cycle", dk, 32'd9);
        repeat (2) @(negedge clock);
        chk("ign_not_queued_busy", {31'd0, busy}, 32'd0);

        // Fresh reset, then 17 back-to-back frames: counts 0..15 then wrap
        reset = 1'b0;
        @(negedge clock);
        reset    = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 37 + 11);
            send(d, 16'h0000, 0, 0, w, dk, fl, acc);
            chk("b2b_word", {24'd0, w}, {24'd0, d});
            chk("b2b_frame", fl, i % 16);
            if (i > 0) chk("b2b_period", acc - prev_acc, 32'd10);
            prev_acc = acc;
        end
        repeat (2) @(negedge clock);

        // Reset asserted in cycle 5 of a frame
        send(8'hC3, 16'h0000, 0, 5, w, dk, fl, acc);
        @(negedge clock);
        send(8'h96, 16'h0000, 0, 0, w, dk, fl, acc);
        chk("post_rst_word", {24'd0, w}, 32'h0000_0096);
        chk("post_rst_frame", fl, 32'd0);
        chk("post_rst_done_cycle", dk, 32'd9);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sender
`default_nettype wire
